// File: rtl/ram_scan_ctrl_if.sv
// Bus bundle for ram_scan_ctrl: write port, scan controls and read-side status.
interface ram_scan_ctrl_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ADDR_W = 5
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              scan_en;
  logic              step;
  logic              rd_restart;
  logic              clear_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              tick;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data, scan_en, step, rd_restart, clear_req,
    input  rd_addr, rd_data, rd_valid, tick, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, scan_en, step, rd_restart, clear_req,
    output rd_addr, rd_data, rd_valid, tick, busy
  );
endinterface

// File: rtl/ram_scan_ctrl.sv
// Dual-port RAM with a read-address scanner (tick-driven or single-stepped) and a
// hardware clear sequencer. Optional macro RAM_SCAN_BYPASS_EN enables write-first
// forwarding onto rd_data when a write (user or clear) targets the current rd_addr.
module ram_scan_ctrl #(
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic            clk,
  input  logic            reset_n,
  ram_scan_ctrl_if.slave  bus
);

  localparam int unsigned       DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0]   DivLast  = DivW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {StNormal, StClear} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic              w_busy;

  logic [DivW-1:0]   r_div, w_div_nxt;
  logic              r_step;
  logic              w_step_edge;
  logic              w_tick, r_tick;
  logic              w_advance;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic              r_addr_stable;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StNormal;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // FSM next state: clear walks clr_ptr 0..DEPTH-1, one word per cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_busy        = 1'b0;
    unique case (r_state)
      StNormal: begin
        if (bus.clear_req) begin
          w_state_nxt   = StClear;
          w_clr_ptr_nxt = '0;
        end
      end
      StClear: begin
        w_busy = 1'b1;
        if (r_clr_ptr == AddrLast) begin
          w_state_nxt = StNormal;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        end
      end
      default: w_state_nxt = StNormal;
    endcase
  end

  // Single write port: clear sequencer owns it while busy, else in-range user writes
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    if (w_busy) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr;
      w_wdata = '0;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < DepthW)) begin
      w_we = 1'b1;
    end
  end

  // Memory array, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_tick      = (r_state == StNormal) && bus.scan_en && (r_div == DivLast);
  assign w_step_edge = bus.step && !r_step;
  assign w_advance   = w_tick || ((r_state == StNormal) && !bus.scan_en && w_step_edge);

  // Divider and pointer next state; restart beats advance but the tick still fires
  always_comb begin
    w_div_nxt     = r_div;
    w_rd_addr_nxt = r_rd_addr;
    if (bus.rd_restart) begin
      w_div_nxt = '0;
    end else if ((r_state == StNormal) && bus.scan_en) begin
      w_div_nxt = w_tick ? '0 : r_div + DivW'(1);
    end
    if (bus.rd_restart) begin
      w_rd_addr_nxt = '0;
    end else if (w_advance) begin
      w_rd_addr_nxt = (r_rd_addr == AddrLast) ? '0 : r_rd_addr + ADDR_W'(1);
    end
  end

  // Read data next state, with optional write-first forwarding
  always_comb begin
    w_rd_data_nxt = r_mem[r_rd_addr];
`ifdef RAM_SCAN_BYPASS_EN
    if (w_we && (w_waddr == r_rd_addr)) begin
      w_rd_data_nxt = w_wdata;
    end
`endif
  end

  // Scanner and read-side registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_step        <= 1'b0;
      r_tick        <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_data     <= '0;
      r_addr_stable <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_step        <= bus.step;
      r_tick        <= w_tick;
      r_rd_addr     <= w_rd_addr_nxt;
      r_rd_data     <= w_rd_data_nxt;
      // Also cleared while busy so the word read alongside the last clear write is not trusted
      r_addr_stable <= (w_rd_addr_nxt == r_rd_addr) && !w_busy;
    end
  end

  assign bus.rd_addr  = r_rd_addr;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_addr_stable && !w_busy;
  assign bus.tick     = r_tick;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl: directed scenarios plus random traffic,
// all compared every cycle against a behavioural model of the memory and scanner.
module tb_ram_scan_ctrl;

  localparam int DW    = 3;
  localparam int AW    = 5;
  localparam int DEPTH = 20;
  localparam int TDIV  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_scan_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_scan_ctrl #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .TICK_DIV(TDIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model state
  int m_mem   [2**AW];
  bit m_known [2**AW];
  int m_ptr, m_div, m_clear_left, m_rd;
  bit m_rd_known, m_valid, m_tick, m_step_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    // Words the clear had not reached yet are unspecified after an abort
    if (m_clear_left > 0) begin
      for (int a = DEPTH - m_clear_left; a < DEPTH; a++) m_known[a] = 1'b0;
    end
    m_clear_left = 0;
    m_ptr = 0;
    m_div = 0;
    m_step_prev = 1'b0;
    m_tick = 1'b0;
    m_valid = 1'b0;
    m_rd = 0;
    m_rd_known = 1'b1;
  endtask

  task automatic model_step();
    bit busy_now, tk, adv;
    int old_ptr, ci, wa;
    busy_now = (m_clear_left > 0);
    old_ptr = m_ptr;
    m_rd = m_mem[m_ptr];
    m_rd_known = m_known[m_ptr];
    if (busy_now) begin
      ci = DEPTH - m_clear_left;
`ifdef RAM_SCAN_BYPASS_EN
      if (ci == m_ptr) begin m_rd = 0; m_rd_known = 1'b1; end
`endif
      m_mem[ci] = 0;
      m_known[ci] = 1'b1;
      m_clear_left--;
    end else if (bus.wr_en) begin
      wa = int'(bus.wr_addr);
      if (wa < DEPTH) begin
`ifdef RAM_SCAN_BYPASS_EN
        if (wa == m_ptr) begin m_rd = int'(bus.wr_data); m_rd_known = 1'b1; end
`endif
        m_mem[wa] = int'(bus.wr_data);
        m_known[wa] = 1'b1;
      end
    end
    tk = !busy_now && bus.scan_en && (m_div == TDIV - 1);
    adv = tk || (!busy_now && !bus.scan_en && bus.step && !m_step_prev);
    m_tick = tk;
    if (bus.rd_restart) m_div = 0;
    else if (!busy_now && bus.scan_en) m_div = (m_div + 1) % TDIV;
    if (bus.rd_restart) m_ptr = 0;
    else if (adv) m_ptr = (m_ptr + 1) % DEPTH;
    m_step_prev = bus.step;
    if (!busy_now && bus.clear_req) m_clear_left = DEPTH;
    m_valid = (m_ptr == old_ptr) && !busy_now && (m_clear_left == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic write_word(input int a, input int d);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = DW'(d);
    cycle();
    bus.wr_en = 1'b0;
  endtask

  task automatic step_once();
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    cycle();
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_on && reset_n) begin
      chk("rd_addr", 32'(bus.rd_addr), 32'(m_ptr));
      chk("tick", 32'(bus.tick), 32'(m_tick));
      chk("busy", 32'(bus.busy), 32'(m_clear_left > 0));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
      if (m_rd_known) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    end
  end

  initial begin
    int n_tick, last_tick, cnt;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.scan_en = 1'b0; bus.step = 1'b0; bus.rd_restart = 1'b0; bus.clear_req = 1'b0;
    for (int a = 0; a < 2**AW; a++) begin m_mem[a] = 0; m_known[a] = 1'b0; end
    m_clear_left = 0;
    model_reset();
    repeat (2) cycle();

    // Reset values
    chk("reset_rd_addr", 32'(bus.rd_addr), 0);
    chk("reset_rd_data", 32'(bus.rd_data), 0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 0);
    chk("reset_tick", 32'(bus.tick), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    cycle();

    // Write 5 <= 6 then single-step to it
    write_word(5, 6);
    repeat (5) step_once();
    chk("step_addr", 32'(bus.rd_addr), 5);
    chk("step_data", 32'(bus.rd_data), 6);
    chk("step_valid", 32'(bus.rd_valid), 1);

    // Read-during-write at the current address
    write_word(5, 5);
    cycle();
    chk("rdw_setup", 32'(bus.rd_data), 5);
    write_word(5, 2);
`ifdef RAM_SCAN_BYPASS_EN
    chk("rdw_first", 32'(bus.rd_data), 2);
`else
    chk("rdw_first", 32'(bus.rd_data), 5);
`endif
    cycle();
    chk("rdw_second", 32'(bus.rd_data), 2);

    // Auto scan: tick period and wrap at DEPTH
    bus.rd_restart = 1'b1;
    cycle();
    bus.rd_restart = 1'b0;
    chk("restart_addr", 32'(bus.rd_addr), 0);
    bus.scan_en = 1'b1;
    n_tick = 0;
    last_tick = 0;
    for (int i = 0; i < TDIV * (DEPTH + 2); i++) begin
      cycle();
      chk("addr_in_range", 32'(int'(bus.rd_addr) < DEPTH), 1);
      if (bus.tick) begin
        n_tick++;
        if (n_tick == 1) chk("first_tick_cycle", 32'(i), 3);
        else chk("tick_gap", 32'(i - last_tick), 4);
        if (n_tick == DEPTH - 1) chk("addr_before_wrap", 32'(bus.rd_addr), DEPTH - 1);
        if (n_tick == DEPTH) chk("addr_after_wrap", 32'(bus.rd_addr), 0);
        last_tick = i;
      end
    end
    bus.scan_en = 1'b0;

    // Fill with 7, clear, writes during busy must be dropped
    for (int a = 0; a < 2**AW; a++) write_word(a, 7);
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (bus.busy) begin
        cnt++;
        bus.wr_en = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
        bus.wr_data = 3'd5;
        bus.clear_req = (cnt == 5);
      end else begin
        bus.wr_en = 1'b0;
        bus.clear_req = 1'b0;
      end
      cycle();
    end
    bus.wr_en = 1'b0;
    bus.clear_req = 1'b0;
    chk("busy_len", 32'(cnt), DEPTH);
    write_word(25, 7);
    bus.rd_restart = 1'b1;
    cycle();
    bus.rd_restart = 1'b0;
    bus.scan_en = 1'b1;
    for (int i = 0; i < TDIV * DEPTH + 4; i++) begin
      cycle();
      if (bus.rd_valid) chk("cleared_word", 32'(bus.rd_data), 0);
    end
    bus.scan_en = 1'b0;

    // Reset in the middle of a clear
    for (int a = 0; a < DEPTH; a++) write_word(a, 7);
    step_once();
    step_once();
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    cnt = 1;
    for (int i = 0; i < 40 && cnt < 11; i++) begin
      cycle();
      if (bus.busy) cnt++;
    end
    chk("busy_before_abort", 32'(bus.busy), 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rd_addr", 32'(bus.rd_addr), 0);
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < 10; k++) begin
      chk("partial_addr", 32'(bus.rd_addr), 32'(k));
      chk("partial_clear", 32'(bus.rd_data), 0);
      step_once();
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en = ($urandom_range(0, 99) < 40);
      bus.wr_addr = AW'($urandom_range(0, 2**AW - 1));
      bus.wr_data = DW'($urandom);
      bus.step = 1'($urandom_range(0, 1));
      bus.rd_restart = ($urandom_range(0, 99) < 3);
      bus.clear_req = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 31) == 0) bus.scan_en = ~bus.scan_en;
      cycle();
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
